conv_frame_loader: RTL and testbench

- Upstream stage of the convolution engine.
- Accepts a serial stream of signed 16-bit Q2.14 words over a valid/ready handshake and packs them into the flattened filter-coefficient and signal vectors.
- Issues a one-cycle load pulse to the engine, then holds off the next frame until the engine reports completion.
- Lets a testbench or front-end feed one frame per convolution without building wide vectors itself.

---
 rtl/conv_frame_loader.sv | 172 +++++++++++++++++
 tb/tb_conv_frame_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_loader.sv
// Frame loader for the convolution engine: packs a serial Q2.14 word stream into
// flat coefficient/signal vectors, pulses load, then waits for the engine to finish.
module conv_frame_loader #(
    parameter int LEN             = 19,
    parameter int SIGNAL_LENGTH_1 = 2400
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [15:0]                      in_data,
    input  logic                             in_last,
    output logic [(LEN+1)*16:0]              flaten_filter_coeff,
    output logic [(SIGNAL_LENGTH_1+1)*16:0]  flaten_signal,
    output logic                             load,
    input  logic                             conv_done,
    output logic                             busy,
    output logic                             frame_err
);

    localparam int COEF_W  = (LEN + 1) * 16;
    localparam int SIG_W   = (SIGNAL_LENGTH_1 + 1) * 16;
    localparam int MAX_IDX = (LEN > SIGNAL_LENGTH_1) ? LEN : SIGNAL_LENGTH_1;
    localparam int CNT_W   = (MAX_IDX < 1) ? 1 : $clog2(MAX_IDX + 1);

    localparam logic [CNT_W-1:0] LAST_COEF = CNT_W'(LEN);
    localparam logic [CNT_W-1:0] LAST_SIG  = CNT_W'(SIGNAL_LENGTH_1);

    typedef enum logic [2:0] {
        ST_COEF,
        ST_SIG,
        ST_FILL_COEF,
        ST_FILL_SIG,
        ST_LOAD,
        ST_WAIT
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [COEF_W-1:0]   coef_q;
    logic [SIG_W-1:0]    sig_q;
    logic                load_q;
    logic                busy_q;
    logic                err_q;
    logic                done_prev_q;
    logic                done_seen_q;

    logic                xfer_d;
    logic                done_rise_d;
    logic [CNT_W-1:0]    cnt_inc_d;
    logic                coef_we_d;
    logic                sig_we_d;
    logic [15:0]         coef_wdata_d;
    logic [15:0]         sig_wdata_d;

    assign in_ready    = ~rst & ((state_q == ST_COEF) | (state_q == ST_SIG));
    assign xfer_d      = in_valid & in_ready;
    assign done_rise_d = conv_done & ~done_prev_q;
    assign cnt_inc_d   = cnt_q + 1'b1;

    // Zero-fill reuses the normal write port, one slot per cycle, with data forced to 0.
    assign coef_we_d    = ((state_q == ST_COEF) & xfer_d) | (state_q == ST_FILL_COEF);
    assign sig_we_d     = ((state_q == ST_SIG) & xfer_d) | (state_q == ST_FILL_SIG);
    assign coef_wdata_d = (state_q == ST_FILL_COEF) ? 16'h0000 : in_data;
    assign sig_wdata_d  = (state_q == ST_FILL_SIG) ? 16'h0000 : in_data;

    assign flaten_filter_coeff = {1'b0, coef_q};
    assign flaten_signal       = {1'b0, sig_q};
    assign load                = load_q;
    assign busy                = busy_q;
    assign frame_err           = err_q;

    // NOTE: the vectors are plain registers, not a RAM, so they are cleared by reset
    // along with the control state; every sequential assignment here is non-blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_COEF;
            cnt_q       <= '0;
            coef_q      <= '0;
            sig_q       <= '0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            done_prev_q <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            load_q      <= 1'b0;
            err_q       <= 1'b0;
            done_prev_q <= conv_done;

            for (int i = 0; i <= LEN; i++) begin
                if (coef_we_d && cnt_q == CNT_W'(i)) begin
                    coef_q[i*16 +: 16] <= coef_wdata_d;
                end
            end
            for (int i = 0; i <= SIGNAL_LENGTH_1; i++) begin
                if (sig_we_d && cnt_q == CNT_W'(i)) begin
                    sig_q[i*16 +: 16] <= sig_wdata_d;
                end
            end

            if (xfer_d) begin
                busy_q <= 1'b1;
            end

            case (state_q)
                ST_COEF: begin
                    if (xfer_d) begin
                        err_q <= in_last;
                        if (cnt_q == LAST_COEF) begin
                            cnt_q   <= '0;
                            state_q <= in_last ? ST_FILL_SIG : ST_SIG;
                        end else begin
                            cnt_q   <= cnt_inc_d;
                            state_q <= in_last ? ST_FILL_COEF : ST_COEF;
                        end
                    end
                end
                ST_SIG: begin
                    if (xfer_d) begin
                        if (cnt_q == LAST_SIG) begin
                            cnt_q   <= '0;
                            err_q   <= ~in_last;
                            load_q  <= 1'b1;
                            state_q <= ST_LOAD;
                        end else begin
                            cnt_q <= cnt_inc_d;
                            if (in_last) begin
                                err_q   <= 1'b1;
                                state_q <= ST_FILL_SIG;
                            end
                        end
                    end
                end
                ST_FILL_COEF: begin
                    if (cnt_q == LAST_COEF) begin
                        cnt_q   <= '0;
                        state_q <= ST_FILL_SIG;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                ST_FILL_SIG: begin
                    if (cnt_q == LAST_SIG) begin
                        cnt_q   <= '0;
                        load_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                ST_LOAD: begin
                    // An edge of conv_done landing in the LOAD cycle still counts.
                    done_seen_q <= done_rise_d;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_rise_d || done_seen_q) begin
                        cnt_q       <= '0;
                        busy_q      <= 1'b0;
                        done_seen_q <= 1'b0;
                        state_q     <= ST_COEF;
                    end
                end
                default: begin
                    state_q <= ST_COEF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_frame_loader.sv
// Directed bench for conv_frame_loader with LEN=2, SIGNAL_LENGTH_1=4.
module tb_conv_frame_loader;

    localparam int LEN = 2;
    localparam int SL1 = 4;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [15:0]           in_data;
    logic                  in_last;
    logic [(LEN+1)*16:0]   coef_vec;
    logic [(SL1+1)*16:0]   sig_vec;
    logic                  load;
    logic                  conv_done;
    logic                  busy;
    logic                  frame_err;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int err_cnt = 0;
    int load_base;
    int err_base;

    logic [15:0] ca [3] = '{16'h4000, 16'hE000, 16'h1000};
    logic [15:0] sa [5] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    logic [15:0] cb [3] = '{16'h7FFF, 16'h8000, 16'h0001};
    logic [15:0] sb [5] = '{16'hFFFF, 16'h8001, 16'h1234, 16'hABCD, 16'h0F0F};
    logic [15:0] sd [5] = '{16'h0009, 16'h000A, 16'h000B, 16'h000C, 16'h000D};
    logic [15:0] cf [3] = '{16'h0A0A, 16'h0B0B, 16'h0C0C};

    conv_frame_loader #(
        .LEN             (LEN),
        .SIGNAL_LENGTH_1 (SL1)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .in_last             (in_last),
        .flaten_filter_coeff (coef_vec),
        .flaten_signal       (sig_vec),
        .load                (load),
        .conv_done           (conv_done),
        .busy                (busy),
        .frame_err           (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) load_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the word is accepted.
    task automatic put_word(input logic [15:0] d, input logic l, input bit gaps);
        int w;
        if (gaps) begin
            for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // last_pos = index 0..7 of the word carrying in_last; 8 means none.
    task automatic send_frame(input logic [15:0] c [3], input logic [15:0] s [5],
                              input int last_pos, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            put_word((i < 3) ? c[i] : s[i-3], i == last_pos, gaps);
            if (i == last_pos) break;
        end
    endtask

    task automatic wait_load(input string tag);
        for (int i = 0; i < 20 && !load; i++) @(negedge clk);
        check(tag, load, 1);
    endtask

    task automatic release_frame();
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; conv_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_load", load, 0);
        check("rst_busy", busy, 0);
        check("rst_err", frame_err, 0);
        check("rst_coef", coef_vec, 0);
        check("rst_sig", sig_vec, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", in_ready, 1);

        // Basic frame, back-to-back words
        load_base = load_cnt; err_base = err_cnt;
        send_frame(ca, sa, 7, 1'b0);
        check("a_load_latency", load, 1);
        check("a_busy", busy, 1);
        check("a_ready_load", in_ready, 0);
        check("a_coef", coef_vec, {1'b0, 16'h1000, 16'hE000, 16'h4000});
        check("a_sig", sig_vec, {1'b0, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1});
        @(negedge clk);
        check("a_load_once", load, 0);
        repeat (3) @(negedge clk);
        check("a_wait_ready", in_ready, 0);
        check("a_load_count", load_cnt - load_base, 1);
        check("a_err_count", err_cnt - err_base, 0);
        release_frame();
        check("a_rel_ready", in_ready, 1);
        check("a_rel_busy", busy, 0);

        // Two frames with random valid gaps
        load_base = load_cnt; err_base = err_cnt;
        send_frame(cb, sb, 7, 1'b1);
        check("b_load", load, 1);
        check("b_coef", coef_vec, {1'b0, 16'h0001, 16'h8000, 16'h7FFF});
        check("b_sig", sig_vec, {1'b0, 16'h0F0F, 16'hABCD, 16'h1234, 16'h8001, 16'hFFFF});
        @(negedge clk);
        release_frame();
        send_frame(ca, sa, 7, 1'b1);
        check("b2_load", load, 1);
        check("b2_coef", coef_vec, {1'b0, 16'h1000, 16'hE000, 16'h4000});
        check("b2_sig", sig_vec, {1'b0, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1});
        @(negedge clk);
        check("b_load_count", load_cnt - load_base, 2);
        check("b_err_count", err_cnt - err_base, 0);
        release_frame();

        // Early in_last on the 2nd signal sample
        load_base = load_cnt; err_base = err_cnt;
        send_frame(ca, sa, 4, 1'b0);
        check("c_err_pulse", frame_err, 1);
        check("c_fill_ready", in_ready, 0);
        wait_load("c_load");
        check("c_sig", sig_vec, {1'b0, 16'h0, 16'h0, 16'h0, 16'h2, 16'h1});
        check("c_coef", coef_vec, {1'b0, 16'h1000, 16'hE000, 16'h4000});
        @(negedge clk);
        check("c_err_count", err_cnt - err_base, 1);
        check("c_load_count", load_cnt - load_base, 1);
        release_frame();

        // Final sample without in_last
        load_base = load_cnt; err_base = err_cnt;
        send_frame(ca, sd, 8, 1'b0);
        check("d_err_pulse", frame_err, 1);
        check("d_load", load, 1);
        check("d_sig", sig_vec, {1'b0, 16'hD, 16'hC, 16'hB, 16'hA, 16'h9});
        @(negedge clk);
        check("d_err_count", err_cnt - err_base, 1);
        check("d_load_count", load_cnt - load_base, 1);
        release_frame();

        // conv_done already high across LOAD must not release
        conv_done = 1'b1;
        send_frame(ca, sa, 7, 1'b0);
        check("e_load", load, 1);
        repeat (4) @(negedge clk);
        check("e_hold_ready", in_ready, 0);
        check("e_hold_busy", busy, 1);
        conv_done = 1'b0;
        @(negedge clk);
        check("e_fall_ready", in_ready, 0);
        conv_done = 1'b1;
        @(negedge clk);
        check("e_rise_ready", in_ready, 1);
        conv_done = 1'b0;

        // Reset after three words, then a fresh frame
        load_base = load_cnt;
        for (int i = 0; i < 3; i++) put_word(16'h1111 * (i + 1), 1'b0, 1'b0);
        check("f_busy_pre", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("f_rst_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("f_coef_clr", coef_vec, 0);
        check("f_sig_clr", sig_vec, 0);
        check("f_busy_clr", busy, 0);
        check("f_load_clr", load, 0);
        check("f_err_clr", frame_err, 0);
        check("f_ready", in_ready, 1);
        send_frame(cf, sa, 7, 1'b0);
        check("f_load", load, 1);
        check("f_coef", coef_vec, {1'b0, 16'h0C0C, 16'h0B0B, 16'h0A0A});
        check("f_sig", sig_vec, {1'b0, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1});
        @(negedge clk);
        check("f_load_count", load_cnt - load_base, 1);
        release_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
